pwm_ramp_ctrl: RTL and testbench

Sequencer that sits in front of one `pwm` instance and slews its duty ratio toward a requested target in bounded steps. It issues each new ratio over the `pwm_update`/`pwm_done` handshake, so motor current never sees a full-scale duty jump. It also provides an immediate brake path and reports status to the register/host side.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/ramp_tick_gen.sv | 23 ++
 rtl/pwm_ramp_ctrl.sv | 124 ++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM encoding, ratio width and ramp step arithmetic (used with optional PWM_RAMP_TIMEOUT_EN)
package pwm_pkg;
    localparam int PWM_RATIO_W = 8;
    localparam int PWM_PERIOD  = 256;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_TICK, ST_UPDATE} state_e;

    // One bounded step from cur toward goal, clamped at goal; 9-bit math so it never wraps
    function automatic logic [PWM_RATIO_W-1:0] ramp_next(
        input logic [PWM_RATIO_W-1:0] cur,
        input logic [PWM_RATIO_W-1:0] goal,
        input logic [3:0]             step
    );
        logic [8:0] st, up, dn;
        st = {5'd0, ((step == 4'd0) ? 4'd1 : step)};
        up = {1'b0, cur} + st;
        dn = {1'b0, cur} - st;
        if (goal > cur)
            ramp_next = (up > {1'b0, goal}) ? goal : up[7:0];
        else
            ramp_next = (dn[8] || dn < {1'b0, goal}) ? goal : dn[7:0];
    endfunction
endpackage

// File: rtl/ramp_tick_gen.sv
// ramp_tick_gen: TICK_DIV prescaler pacing ramp steps, held at zero while clear_i is high
module ramp_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    output logic tc_o
);
    logic [15:0] cnt_q;

    assign tc_o = ~clear_i && (cnt_q == 16'(TICK_DIV - 1));

    // Free count 0..TICK_DIV-1, restarted on clear and on terminal count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else if (clear_i || tc_o)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 16'd1;
    end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: slews pwm duty toward a goal in bounded steps over the update/done handshake; PWM_RAMP_TIMEOUT_EN adds a handshake watchdog
module pwm_ramp_ctrl import pwm_pkg::*; #(
    parameter int TICK_DIV       = 1000,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   brake,
    input  logic [PWM_RATIO_W-1:0] target_ratio,
    input  logic                   target_valid,
    input  logic [3:0]             step_size,
    input  logic                   pwm_done,
    output logic [PWM_RATIO_W-1:0] pwm_ratio,
    output logic                   pwm_update,
    output logic                   pwm_enable,
    output logic [PWM_RATIO_W-1:0] current_ratio,
    output logic                   busy,
    output logic                   at_target,
    output logic                   err
);
    state_e                 state_q;
    logic [PWM_RATIO_W-1:0] goal_q, goal_d, cur_q, ratio_q, nxt;
    logic                   upd_q, en_q, tc, timeout, halt;

    ramp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .clear_i (state_q != ST_WAIT_TICK),
        .tc_o    (tc)
    );

    // Brake pins the goal to zero ahead of any host retarget
    always_comb goal_d = brake ? '0 : (target_valid ? target_ratio : goal_q);

    assign nxt = ramp_next(cur_q, goal_d, step_size);

`ifdef PWM_RAMP_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    logic        err_q, halt_q;

    assign timeout = (state_q == ST_UPDATE) && !pwm_done && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign halt    = halt_q && !target_valid;
    assign err     = err_q;

    // Handshake watchdog; a timeout parks the sequencer until the host retargets
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == ST_UPDATE && !timeout) ? to_cnt_q + 16'd1 : '0;
            err_q    <= timeout | (err_q & ~target_valid);
            halt_q   <= timeout | (halt_q & ~target_valid);
        end
    end
`else
    assign timeout = 1'b0;
    assign halt    = 1'b0;
    assign err     = 1'b0;
`endif

    // Step sequencer: wait one tick, issue one bounded step, hold it until pwm acknowledges
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            goal_q  <= '0;
            cur_q   <= '0;
            ratio_q <= '0;
            upd_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            goal_q <= goal_d;
            en_q   <= enable & ~brake;
            case (state_q)
                ST_IDLE: begin
                    if (goal_d != cur_q && !halt) begin
                        if (brake) begin
                            ratio_q <= '0;
                            upd_q   <= 1'b1;
                            state_q <= ST_UPDATE;
                        end else begin
                            state_q <= ST_WAIT_TICK;
                        end
                    end
                end
                ST_WAIT_TICK: begin
                    if (brake) begin
                        ratio_q <= '0;
                        upd_q   <= 1'b1;
                        state_q <= ST_UPDATE;
                    end else if (tc) begin
                        if (goal_d == cur_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            ratio_q <= nxt;
                            upd_q   <= 1'b1;
                            state_q <= ST_UPDATE;
                        end
                    end
                end
                ST_UPDATE: begin
                    if (timeout) begin
                        upd_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (pwm_done) begin
                        cur_q   <= ratio_q;
                        upd_q   <= 1'b0;
                        state_q <= (goal_d == ratio_q) ? ST_IDLE : ST_WAIT_TICK;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pwm_ratio     = ratio_q;
    assign pwm_update    = upd_q;
    assign pwm_enable    = en_q;
    assign current_ratio = cur_q;
    assign busy          = (state_q != ST_IDLE);
    assign at_target     = (state_q == ST_IDLE) && (cur_q == goal_q);
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: scoreboard bench for pwm_ramp_ctrl with a behavioural pwm acknowledging at counter wrap
module tb_pwm_ramp_ctrl;
    localparam int TD = 4;

    logic       clock = 1'b0, reset_n = 1'b1, enable = 1'b0, brake = 1'b0, target_valid = 1'b0;
    logic [7:0] target_ratio = 8'd0;
    logic [3:0] step_size = 4'd0;
    logic       pwm_done, pwm_update, pwm_enable, busy, at_target, err;
    logic [7:0] pwm_ratio, current_ratio;
    logic [7:0] pcnt;
    logic       stall = 1'b0;
    int         checks = 0, errors = 0;
    logic [7:0] exp_q[$];

    pwm_ramp_ctrl #(.TICK_DIV(TD), .TIMEOUT_CYCLES(300)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .brake(brake),
        .target_ratio(target_ratio), .target_valid(target_valid), .step_size(step_size),
        .pwm_done(pwm_done), .pwm_ratio(pwm_ratio), .pwm_update(pwm_update),
        .pwm_enable(pwm_enable), .current_ratio(current_ratio), .busy(busy),
        .at_target(at_target), .err(err)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n)
        if (!reset_n) pcnt <= 8'd0;
        else pcnt <= pcnt + 8'd1;

    assign pwm_done = pwm_update && (pcnt == 8'hff) && !stall;

    always @(negedge clock) begin
        logic [7:0] e;
        if (reset_n && pwm_update && pwm_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected ratio=%0d required=none", pwm_ratio);
            end else begin
                e = exp_q.pop_front();
                if (pwm_ratio !== e) begin
                    errors++;
                    $display("FAIL ack_ratio got=%0d exp=%0d", pwm_ratio, e);
                end
            end
        end
    end

    task automatic pulse(input logic [7:0] v);
        @(negedge clock);
        target_ratio = v;
        target_valid = 1'b1;
        @(negedge clock);
        target_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(at_target && !busy) && n < 20000);
        checks++;
        if (!(at_target && !busy)) begin
            errors++;
            $display("FAIL %s_idle_timeout busy=%0b at_target=%0b", name, busy, at_target);
        end
    endtask

    task automatic check_end(input string name, input logic [7:0] cur);
        checks++;
        if (current_ratio !== cur || at_target !== 1'b1) begin
            errors++;
            $display("FAIL %s_end cur=%0d at=%0b exp cur=%0d at=1", name, current_ratio, at_target, cur);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got=%0d exp=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({pwm_ratio, current_ratio, pwm_update, pwm_enable, busy, err, at_target} !== {8'd0, 8'd0, 5'b00001}) begin
            errors++;
            $display("FAIL reset ratio=%0d cur=%0d upd=%0b en=%0b busy=%0b err=%0b at=%0b exp 0/0/0/0/0/0/1",
                     pwm_ratio, current_ratio, pwm_update, pwm_enable, busy, err, at_target);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        enable = 1'b1;
        @(negedge clock);
        checks++;
        if (pwm_enable !== 1'b1) begin
            errors++;
            $display("FAIL enable got=%0b exp=1", pwm_enable);
        end
    endtask

    task automatic test_ramp_up();
        int k = 0;
        step_size = 4'd10;
        exp_q.push_back(8'd10);
        exp_q.push_back(8'd20);
        exp_q.push_back(8'd25);
        pulse(8'd25);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL up_wait_tick busy=%0b exp=1", busy);
        end
        k = 1;
        while (!pwm_update && k < 50) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (k != TD + 1) begin
            errors++;
            $display("FAIL up_latency got=%0d exp=%0d", k, TD + 1);
        end
        wait_idle("up");
        check_end("up", 8'd25);
    endtask

    task automatic test_ramp_down();
        int v = 25;
        step_size = 4'd15;
        while (v != 200) begin
            v = (v + 15 > 200) ? 200 : v + 15;
            exp_q.push_back(8'(v));
        end
        pulse(8'd200);
        wait_idle("to200");
        check_end("to200", 8'd200);
        step_size = 4'd0;
        exp_q.push_back(8'd199);
        exp_q.push_back(8'd198);
        exp_q.push_back(8'd197);
        pulse(8'd197);
        wait_idle("down");
        check_end("down", 8'd197);
    endtask

    task automatic test_brake();
        int n = 0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        step_size = 4'd8;
        for (int v = 8; v <= 64; v += 8) exp_q.push_back(8'(v));
        pulse(8'd200);
        while (!(current_ratio == 8'd64 && busy && !pwm_update) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (current_ratio !== 8'd64) begin
            errors++;
            $display("FAIL brake_setup cur=%0d exp=64", current_ratio);
        end
        exp_q.push_back(8'd0);
        brake = 1'b1;
        @(negedge clock);
        checks++;
        if (pwm_enable !== 1'b0 || pwm_update !== 1'b1 || pwm_ratio !== 8'd0) begin
            errors++;
            $display("FAIL brake_response en=%0b upd=%0b ratio=%0d exp en=0 upd=1 ratio=0", pwm_enable, pwm_update, pwm_ratio);
        end
        wait_idle("brake");
        check_end("brake", 8'd0);
        brake = 1'b0;
    endtask

    task automatic test_retarget();
        int n = 0;
        step_size = 4'd10;
        for (int v = 10; v <= 40; v += 10) exp_q.push_back(8'(v));
        pulse(8'd50);
        while (!(pwm_update && pwm_ratio == 8'd40) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        exp_q.push_back(8'd30);
        exp_q.push_back(8'd20);
        exp_q.push_back(8'd10);
        target_ratio = 8'd10;
        target_valid = 1'b1;
        @(negedge clock);
        target_valid = 1'b0;
        checks++;
        if (pwm_ratio !== 8'd40) begin
            errors++;
            $display("FAIL retarget_inflight ratio=%0d exp=40", pwm_ratio);
        end
        wait_idle("retarget");
        check_end("retarget", 8'd10);
    endtask

    task automatic test_stall();
        int k = 1;
        stall = 1'b1;
        step_size = 4'd15;
`ifndef PWM_RAMP_TIMEOUT_EN
        exp_q.push_back(8'd25);
        exp_q.push_back(8'd40);
        exp_q.push_back(8'd55);
        exp_q.push_back(8'd60);
`endif
        pulse(8'd60);
        while (!pwm_update && k < 50) begin
            @(negedge clock);
            k++;
        end
`ifdef PWM_RAMP_TIMEOUT_EN
        k = 1;
        while (k < 298) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (err !== 1'b0 || pwm_update !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early err=%0b upd=%0b exp err=0 upd=1", err, pwm_update);
        end
        while (!err && k < 310) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (k < 299 || k > 302 || pwm_update !== 1'b0 || current_ratio !== 8'd10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout cycle=%0d upd=%0b cur=%0d busy=%0b exp cycle=300 upd=0 cur=10 busy=0",
                     k, pwm_update, current_ratio, busy);
        end
        repeat (20) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_parked busy=%0b err=%0b exp busy=0 err=1", busy, err);
        end
        stall = 1'b0;
        pulse(8'd10);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got=%0b exp=0", err);
        end
        wait_idle("stall");
        check_end("stall", 8'd10);
`else
        repeat (400) @(negedge clock);
        checks++;
        if (err !== 1'b0 || pwm_update !== 1'b1 || busy !== 1'b1 || pwm_ratio !== 8'd25) begin
            errors++;
            $display("FAIL stall_hold err=%0b upd=%0b busy=%0b ratio=%0d exp 0/1/1/25", err, pwm_update, busy, pwm_ratio);
        end
        stall = 1'b0;
        wait_idle("stall");
        check_end("stall", 8'd60);
`endif
    endtask

    task automatic test_async_reset();
        int n = 0;
        step_size = 4'd15;
        pulse(8'd200);
        while (!pwm_update && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({pwm_ratio, current_ratio, pwm_update, pwm_enable, busy, err, at_target} !== {8'd0, 8'd0, 5'b00001}) begin
            errors++;
            $display("FAIL async_reset ratio=%0d cur=%0d upd=%0b en=%0b busy=%0b err=%0b at=%0b exp 0/0/0/0/0/0/1",
                     pwm_ratio, current_ratio, pwm_update, pwm_enable, busy, err, at_target);
        end
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_brake();
        test_retarget();
        test_stall();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
